// File: rtl/dcache_store_buf.sv
// Coalescing store buffer with load priority on one SRAM port (load data 1 cycle after accept); DCACHE_SB_FWD_EN adds load forwarding.
// oReqRdy drops during flush and for loads when full; without forwarding it also drops for loads that hit a buffered store.
module dcache_store_buf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iReqEn,
  input  logic                iReqWr,
  input  logic [ADDR_W-1:0]   iReqAddr,
  input  logic [DATA_W/8-1:0] iReqMask,
  input  logic [DATA_W-1:0]   iReqData,
  output logic                oReqRdy,
  output logic                oRdValid,
  output logic [DATA_W-1:0]   oRdData,
  output logic                oSramCen,
  output logic                oSramWe,
  output logic [ADDR_W-1:0]   oSramAddr,
  output logic [DATA_W/8-1:0] oSramMask,
  output logic [DATA_W-1:0]   oSramWData,
  input  logic [DATA_W-1:0]   iSramRData,
  input  logic                iFlush,
  output logic                oFlushDone,
  output logic                oEmpty,
  output logic                oFull
);
  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  entry_t            ent [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  state_t            state, stateNext;
  logic              rdValidQ;

  logic              full, empty, reqRdy, reqAcc, loadAcc, storeAcc, drain, alloc, mergeHit;
  logic [DEPTH-1:0]  addrHit;
  logic [PTR_W-1:0]  mergeIdx;
  logic [DATA_W-1:0] mergedData;

`ifdef DCACHE_SB_FWD_EN
  logic [MASK_W-1:0] fwdMask, capMask;
  logic [DATA_W-1:0] fwdData, capData;
`endif

  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    for (int i = 0; i < DEPTH; i++) begin
      addrHit[i] = ent[i].valid && (ent[i].addr == iReqAddr);
    end

    reqRdy = 1'b0;
    if (state != FLUSH) begin
      if (iReqWr) begin
        reqRdy = 1'b1;
      end else begin
`ifdef DCACHE_SB_FWD_EN
        reqRdy = !full;
`else
        reqRdy = !full && !(|addrHit);
`endif
      end
    end
    reqAcc   = iReqEn && reqRdy;
    loadAcc  = reqAcc && !iReqWr;
    storeAcc = reqAcc && iReqWr;
    // Drain only in cycles with no accepted request, except when full so a store can still enter.
    drain    = !empty && (full || !reqAcc);

    mergeHit = 1'b0;
    mergeIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addrHit[i] && !(drain && (PTR_W'(i) == head))) begin
        mergeHit = 1'b1;
        mergeIdx = PTR_W'(i);
      end
    end
    alloc = storeAcc && !mergeHit;

    mergedData = ent[mergeIdx].data;
    for (int b = 0; b < MASK_W; b++) begin
      if (iReqMask[b]) mergedData[8*b +: 8] = iReqData[8*b +: 8];
    end
  end

`ifdef DCACHE_SB_FWD_EN
  always_comb begin
    fwdMask = '0;
    fwdData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addrHit[i]) begin
        fwdMask = fwdMask | ent[i].mask;
        fwdData = fwdData | ent[i].data;
      end
    end
  end
`endif

  always_comb begin
    oSramCen   = 1'b0;
    oSramWe    = 1'b0;
    oSramAddr  = '0;
    oSramMask  = '0;
    oSramWData = '0;
    if (!rst) begin
      if (loadAcc) begin
        oSramCen  = 1'b1;
        oSramAddr = iReqAddr;
      end else if (drain) begin
        oSramCen   = 1'b1;
        oSramWe    = 1'b1;
        oSramAddr  = ent[head].addr;
        oSramMask  = ent[head].mask;
        oSramWData = ent[head].data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rdValidQ <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
`ifdef DCACHE_SB_FWD_EN
      capMask  <= '0;
      capData  <= '0;
`endif
    end else begin
      rdValidQ <= loadAcc;
`ifdef DCACHE_SB_FWD_EN
      if (loadAcc) begin
        capMask <= fwdMask;
        capData <= fwdData;
      end
`endif
      if (drain) begin
        ent[head].valid <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      // When full, tail equals head: the allocate below must win over the pop above.
      if (storeAcc) begin
        if (mergeHit) begin
          ent[mergeIdx].mask <= ent[mergeIdx].mask | iReqMask;
          ent[mergeIdx].data <= mergedData;
        end else begin
          ent[tail] <= '{valid: 1'b1, addr: iReqAddr, mask: iReqMask, data: iReqData};
          tail      <= tail + PTR_W'(1);
        end
      end
      count <= count + {{(CNT_W-1){1'b0}}, alloc} - {{(CNT_W-1){1'b0}}, drain};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iFlush) stateNext = FLUSH;
      FLUSH:   if (empty)  stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    oRdData = '0;
    if (rdValidQ) begin
`ifdef DCACHE_SB_FWD_EN
      for (int b = 0; b < MASK_W; b++) begin
        oRdData[8*b +: 8] = capMask[b] ? capData[8*b +: 8] : iSramRData[8*b +: 8];
      end
`else
      oRdData = iSramRData;
`endif
    end
  end

  assign oReqRdy    = reqRdy;
  assign oRdValid   = rdValidQ;
  assign oFlushDone = (state == DONE);
  assign oEmpty     = empty;
  assign oFull      = full;

endmodule

// File: tb/tb_dcache_store_buf.sv
// Directed bench for dcache_store_buf with a behavioural SRAM; expectations follow DCACHE_SB_FWD_EN.
module tb_dcache_store_buf;
  logic        clk, rst, iReqEn, iReqWr;
  logic [11:0] iReqAddr;
  logic [3:0]  iReqMask;
  logic [31:0] iReqData;
  logic        oReqRdy, oRdValid;
  logic [31:0] oRdData;
  logic        oSramCen, oSramWe;
  logic [11:0] oSramAddr;
  logic [3:0]  oSramMask;
  logic [31:0] oSramWData, iSramRData;
  logic        iFlush, oFlushDone, oEmpty, oFull;

  int nCmp = 0;
  int nErr = 0;

  typedef struct packed {
    logic [11:0] a;
    logic [3:0]  m;
    logic [31:0] d;
  } wr_t;
  wr_t         wrLog [$];
  logic [31:0] mem [4096];
  logic        preWe;
  logic [11:0] preA;
  logic [31:0] preD;

  dcache_store_buf #(.DEPTH(4), .ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .iReqEn(iReqEn), .iReqWr(iReqWr), .iReqAddr(iReqAddr),
    .iReqMask(iReqMask), .iReqData(iReqData), .oReqRdy(oReqRdy), .oRdValid(oRdValid),
    .oRdData(oRdData), .oSramCen(oSramCen), .oSramWe(oSramWe), .oSramAddr(oSramAddr),
    .oSramMask(oSramMask), .oSramWData(oSramWData), .iSramRData(iSramRData),
    .iFlush(iFlush), .oFlushDone(oFlushDone), .oEmpty(oEmpty), .oFull(oFull)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $fatal(1, "watchdog timeout");
  end

  // Synchronous SRAM: byte-masked write, registered read.
  always @(posedge clk) begin
    if (preWe) mem[preA] <= preD;
    if (oSramCen && oSramWe) begin
      for (int b = 0; b < 4; b++) if (oSramMask[b]) mem[oSramAddr][8*b +: 8] <= oSramWData[8*b +: 8];
      wrLog.push_back({oSramAddr, oSramMask, oSramWData});
    end
    if (oSramCen && !oSramWe) iSramRData <= mem[oSramAddr];
  end

  task automatic setStore(input logic [11:0] a, input logic [3:0] m, input logic [31:0] d);
    iReqEn = 1'b1; iReqWr = 1'b1; iReqAddr = a; iReqMask = m; iReqData = d;
  endtask

  task automatic setLoad(input logic [11:0] a);
    iReqEn = 1'b1; iReqWr = 1'b0; iReqAddr = a; iReqMask = 4'h0; iReqData = 32'h0;
  endtask

  task automatic idleReq();
    iReqEn = 1'b0; iReqWr = 1'b0; iReqAddr = 12'h0; iReqMask = 4'h0; iReqData = 32'h0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); preWe = 1'b1; preA = a; preD = d;
    @(negedge clk); preWe = 1'b0;
  endtask

  task automatic drainAll(input string tag);
    int k;
    k = 0;
    idleReq();
    while (oEmpty !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    nCmp++; if (oEmpty !== 1'b1) begin nErr++; $display("FAIL %s_drain: oEmpty=%b want 1", tag, oEmpty); end
  endtask

  task automatic test_reset();
    @(negedge clk); setLoad(12'h010); #1;
    nCmp++; if (oRdValid !== 1'b0)    begin nErr++; $display("FAIL rst_rdvalid: got %b want 0", oRdValid); end
    nCmp++; if (oRdData !== 32'h0)    begin nErr++; $display("FAIL rst_rddata: got %h want 0", oRdData); end
    nCmp++; if (oFlushDone !== 1'b0)  begin nErr++; $display("FAIL rst_flushdone: got %b want 0", oFlushDone); end
    nCmp++; if (oEmpty !== 1'b1)      begin nErr++; $display("FAIL rst_empty: got %b want 1", oEmpty); end
    nCmp++; if (oFull !== 1'b0)       begin nErr++; $display("FAIL rst_full: got %b want 0", oFull); end
    nCmp++; if (oSramCen !== 1'b0)    begin nErr++; $display("FAIL rst_sramcen: got %b want 0", oSramCen); end
    idleReq();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_store_load();
    int base;
    base = wrLog.size();
    @(negedge clk); setStore(12'h010, 4'hF, 32'hDEADBEEF); #1;
    nCmp++; if (oReqRdy !== 1'b1)  begin nErr++; $display("FAIL sl_store_rdy: got %b want 1", oReqRdy); end
    nCmp++; if (oSramCen !== 1'b0) begin nErr++; $display("FAIL sl_store_nocen: got %b want 0", oSramCen); end
    @(negedge clk); setLoad(12'h010);
`ifndef DCACHE_SB_FWD_EN
    #1;
    nCmp++; if (oReqRdy !== 1'b0) begin nErr++; $display("FAIL sl_stall_rdy: got %b want 0", oReqRdy); end
    nCmp++; if ({oSramWe, oSramAddr, oSramWData} !== {1'b1, 12'h010, 32'hDEADBEEF})
      begin nErr++; $display("FAIL sl_stall_drain: got we=%b a=%h d=%h want 1/010/deadbeef", oSramWe, oSramAddr, oSramWData); end
    @(negedge clk);
`endif
    #1;
    nCmp++; if (oReqRdy !== 1'b1) begin nErr++; $display("FAIL sl_load_rdy: got %b want 1", oReqRdy); end
    nCmp++; if ({oSramCen, oSramWe, oSramAddr} !== {1'b1, 1'b0, 12'h010})
      begin nErr++; $display("FAIL sl_load_read: got cen=%b we=%b a=%h want 1/0/010", oSramCen, oSramWe, oSramAddr); end
`ifdef DCACHE_SB_FWD_EN
    nCmp++; if (wrLog.size() != base) begin nErr++; $display("FAIL sl_no_write: got %0d writes want 0", wrLog.size() - base); end
`endif
    @(negedge clk); idleReq();
    nCmp++; if ({oRdValid, oRdData} !== {1'b1, 32'hDEADBEEF})
      begin nErr++; $display("FAIL sl_data: got v=%b d=%h want 1/deadbeef", oRdValid, oRdData); end
    @(negedge clk);
    nCmp++; if (oRdValid !== 1'b0) begin nErr++; $display("FAIL sl_one_shot: got %b want 0", oRdValid); end
    drainAll("sl");
  endtask

  task automatic test_coalesce();
    int base;
    base = wrLog.size();
    @(negedge clk); setStore(12'h020, 4'b0011, 32'h00001234);
    @(negedge clk); setStore(12'h020, 4'b1100, 32'hABCD0000); #1;
    nCmp++; if (oSramCen !== 1'b0) begin nErr++; $display("FAIL co_nodrain: got %b want 0", oSramCen); end
    @(negedge clk); idleReq();
    nCmp++; if (oEmpty !== 1'b0) begin nErr++; $display("FAIL co_nonempty: got %b want 0", oEmpty); end
    #1;
    nCmp++; if ({oSramWe, oSramAddr, oSramMask, oSramWData} !== {1'b1, 12'h020, 4'hF, 32'hABCD1234})
      begin nErr++; $display("FAIL co_drain: got we=%b a=%h m=%h d=%h want 1/020/f/abcd1234", oSramWe, oSramAddr, oSramMask, oSramWData); end
    @(negedge clk);
    nCmp++; if (oEmpty !== 1'b1) begin nErr++; $display("FAIL co_single_entry: oEmpty=%b want 1", oEmpty); end
    nCmp++; if (wrLog.size() != base + 1) begin nErr++; $display("FAIL co_writes: got %0d want 1", wrLog.size() - base); end
  endtask

  task automatic test_partial();
    @(negedge clk); setStore(12'h030, 4'b0001, 32'h000000AA);
    @(negedge clk); setLoad(12'h030);
`ifndef DCACHE_SB_FWD_EN
    #1;
    nCmp++; if (oReqRdy !== 1'b0) begin nErr++; $display("FAIL pf_stall: got %b want 0", oReqRdy); end
    @(negedge clk);
`endif
    #1;
    nCmp++; if (oReqRdy !== 1'b1) begin nErr++; $display("FAIL pf_rdy: got %b want 1", oReqRdy); end
    @(negedge clk); idleReq();
    nCmp++; if ({oRdValid, oRdData} !== {1'b1, 32'h112233AA})
      begin nErr++; $display("FAIL pf_data: got v=%b d=%h want 1/112233aa", oRdValid, oRdData); end
    drainAll("pf");
  endtask

  task automatic test_fill();
    int base;
    base = wrLog.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); setStore(12'h100 + 12'(i), 4'hF, 32'h10000000 + i); #1;
      nCmp++; if ({oReqRdy, oSramCen} !== 2'b10) begin nErr++; $display("FAIL fill_st%0d: got rdy=%b cen=%b want 1/0", i, oReqRdy, oSramCen); end
    end
    @(negedge clk); idleReq();
    nCmp++; if (oFull !== 1'b1) begin nErr++; $display("FAIL fill_full: got %b want 1", oFull); end
    drainAll("fill");
    nCmp++; if (wrLog.size() != base + 4) begin nErr++; $display("FAIL fill_nwr: got %0d want 4", wrLog.size() - base); end
    for (int i = 0; i < 4 && base + i < wrLog.size(); i++) begin
      nCmp++; if ({wrLog[base+i].a, wrLog[base+i].d} !== {12'h100 + 12'(i), 32'h10000000 + i})
        begin nErr++; $display("FAIL fill_wr%0d: got a=%h d=%h want a=%h", i, wrLog[base+i].a, wrLog[base+i].d, 12'h100 + 12'(i)); end
    end
  endtask

  task automatic test_full_load();
    int base;
    base = wrLog.size();
    @(negedge clk); setStore(12'h200, 4'hF, 32'h20000000);
    @(negedge clk); setLoad(12'h300);
    @(negedge clk); setStore(12'h201, 4'hF, 32'h20000001);
    @(negedge clk); setLoad(12'h300);
    @(negedge clk); setStore(12'h202, 4'hF, 32'h20000002);
    @(negedge clk); setStore(12'h203, 4'hF, 32'h20000003);
    @(negedge clk); setLoad(12'h300); #1;
    nCmp++; if (oReqRdy !== 1'b0) begin nErr++; $display("FAIL fl_full_rdy: got %b want 0", oReqRdy); end
    nCmp++; if ({oSramWe, oSramAddr} !== {1'b1, 12'h200}) begin nErr++; $display("FAIL fl_forced_drain: got we=%b a=%h want 1/200", oSramWe, oSramAddr); end
    @(negedge clk); #1;
    nCmp++; if ({oReqRdy, oSramCen, oSramWe, oSramAddr} !== {1'b1, 1'b1, 1'b0, 12'h300})
      begin nErr++; $display("FAIL fl_load_accept: got rdy=%b cen=%b we=%b a=%h want 1/1/0/300", oReqRdy, oSramCen, oSramWe, oSramAddr); end
    @(negedge clk); idleReq();
    nCmp++; if ({oRdValid, oRdData} !== {1'b1, 32'hCAFEF00D})
      begin nErr++; $display("FAIL fl_data: got v=%b d=%h want 1/cafef00d", oRdValid, oRdData); end
    drainAll("fl");
    nCmp++; if (wrLog.size() != base + 4) begin nErr++; $display("FAIL fl_nwr: got %0d want 4", wrLog.size() - base); end
    for (int i = 0; i < 4 && base + i < wrLog.size(); i++) begin
      nCmp++; if (wrLog[base+i].a !== 12'h200 + 12'(i)) begin nErr++; $display("FAIL fl_order%0d: got %h want %h", i, wrLog[base+i].a, 12'h200 + 12'(i)); end
    end
  endtask

  task automatic test_flush();
    int base;
    base = wrLog.size();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); setStore(12'h040 + 12'(i), 4'hF, 32'h40000000 + i);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      iFlush = (k == 0);
      if (k >= 1 && k <= 3) setLoad(12'h300); else idleReq();
      #1;
      if (k >= 1 && k <= 3) begin
        nCmp++; if (oReqRdy !== 1'b0) begin nErr++; $display("FAIL fs_rdy_k%0d: got %b want 0", k, oReqRdy); end
      end
      nCmp++; if (oFlushDone !== (k == 4)) begin nErr++; $display("FAIL fs_done_k%0d: got %b want %b", k, oFlushDone, k == 4); end
    end
    idleReq();
    nCmp++; if (oEmpty !== 1'b1) begin nErr++; $display("FAIL fs_empty: got %b want 1", oEmpty); end
    nCmp++; if (wrLog.size() != base + 3) begin nErr++; $display("FAIL fs_nwr: got %0d want 3", wrLog.size() - base); end
    for (int i = 0; i < 3 && base + i < wrLog.size(); i++) begin
      nCmp++; if (wrLog[base+i].a !== 12'h040 + 12'(i)) begin nErr++; $display("FAIL fs_order%0d: got %h want %h", i, wrLog[base+i].a, 12'h040 + 12'(i)); end
    end
  endtask

  task automatic test_flush_empty();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); iFlush = (k == 0); idleReq(); #1;
      nCmp++; if (oFlushDone !== (k == 2)) begin nErr++; $display("FAIL fe_done_k%0d: got %b want %b", k, oFlushDone, k == 2); end
    end
    iFlush = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    @(negedge clk); setStore(12'h050, 4'hF, 32'h50000000);
    @(negedge clk); setStore(12'h051, 4'hF, 32'h50000001);
    @(negedge clk); setLoad(12'h300); #1;
    nCmp++; if (oReqRdy !== 1'b1) begin nErr++; $display("FAIL rm_load_rdy: got %b want 1", oReqRdy); end
    @(negedge clk);
    nCmp++; if (oRdValid !== 1'b1) begin nErr++; $display("FAIL rm_inflight: got %b want 1", oRdValid); end
    rst = 1'b1; idleReq(); #1;
    base = wrLog.size();
    nCmp++; if ({oRdValid, oRdData} !== {1'b0, 32'h0}) begin nErr++; $display("FAIL rm_rdvalid: got v=%b d=%h want 0/0", oRdValid, oRdData); end
    nCmp++; if ({oEmpty, oFull, oSramCen} !== 3'b100) begin nErr++; $display("FAIL rm_status: got e=%b f=%b cen=%b want 1/0/0", oEmpty, oFull, oSramCen); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    nCmp++; if (wrLog.size() != base) begin nErr++; $display("FAIL rm_no_write: got %0d writes want 0", wrLog.size() - base); end
    nCmp++; if (oEmpty !== 1'b1) begin nErr++; $display("FAIL rm_empty: got %b want 1", oEmpty); end
  endtask

  initial begin
    rst = 1'b1; iFlush = 1'b0; preWe = 1'b0; preA = 12'h0; preD = 32'h0;
    idleReq();
    preload(12'h010, 32'h00000000);
    preload(12'h030, 32'h11223344);
    preload(12'h300, 32'hCAFEF00D);
    test_reset();
    test_store_load();
    test_coalesce();
    test_partial();
    test_fill();
    test_full_load();
    test_flush();
    test_flush_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
